fir_sym_mac: RTL and testbench
==============================

# fir_sym_mac

Sequencer and multiply-accumulate stage of the symmetric 16-tap FIR. It holds the sample delay line and walks the half-length coefficient ROM address space. It pre-adds mirrored tap pairs, multiplies each pair by the coefficient the ROM returns, and accumulates the result. It sits directly downstream of the sample source, drives the coefficient ROM's `add` port, and consumes that ROM's `q` output. It produces one saturated filter output per accepted sample.

## Interface
- `WIDTH_DATA`, 8, sample width, signed two's complement
- `WIDTH_COEF0`, 8, coefficient width; the ROM word is treated as signed
- `N_TAPS`, 16, filter length; must be an even power of two ≥ 4; the ROM depth is `N_TAPS/2`
- `WIDTH_MAC_OUT`, 8, output width, signed
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before saturation
- `clk` in 1: the single clock; all state updates on its rising edge
- `clr` in 1: synchronous, active-high reset
- `din` in `WIDTH_DATA`: input sample
- `in_valid` in 1: `din` is valid this cycle
- `in_ready` out 1: block can accept a sample
- `add` out `$clog2(N_TAPS/2)`: coefficient ROM address, registered
- `q` in `WIDTH_COEF0`: ROM data, valid one cycle after `add` (registered ROM read)
- `dout` out `WIDTH_MAC_OUT`: filter output, held until the next result
- `out_valid` out 1: one-cycle pulse marking a new `dout`

## Operation
- **Delay line:** `x[0..N_TAPS-1]`, `WIDTH_DATA` each. On accept, `x[0] <= din` and `x[k] <= x[k-1]`. It shifts only on accept.
- **Pre-add:** `p_k = x[k] + x[N_TAPS-1-k]`, sign-extended to `WIDTH_DATA+1`.
- **Accumulator width:** `WIDTH_DATA+1+WIDTH_COEF0+$clog2(N_TAPS/2)`, signed. It never overflows internally.
- **Output:** `dout = sat(acc >>> SHIFT)` to the signed `WIDTH_MAC_OUT` range, clamped to [-2^(W-1), 2^(W-1)-1].
- **States:** IDLE, RUN, DRAIN.
- **IDLE:** `in_ready=1`. If `in_valid`, accept the sample, clear `acc`, set `add<=0`, go to RUN.
- **RUN:** lasts `N_TAPS/2` cycles.
  - In each cycle the current `add=k` is presented and `p_k` is registered (`p_reg`).
  - From the second RUN cycle onward, `acc <= acc + p_reg_prev * q`.
  - `add` increments each cycle. After `add = N_TAPS/2-1`, go to DRAIN; `add` stays at its last value, with no wrap.
- **DRAIN:** one cycle.
  - Adds the final product.
  - Registers `dout` from the completed sum.
  - Sets `out_valid<=1` for the next cycle.
  - Returns to IDLE.
- **Back-to-back:** `out_valid` coincides with the first IDLE cycle, so a sample offered then is accepted. Back-to-back operation carries no bubble beyond the sequence itself.
- **Input gating:** `in_valid` is ignored outside IDLE. The source must hold `din`/`in_valid` until `in_ready`.
- **No output backpressure:** `dout` is overwritten only by the next DRAIN.
- **`clr`:** has priority over everything, including mid-RUN/DRAIN.
  - Next cycle: state IDLE, the delay line all zeros, `acc=0`, `p_reg=0`, `add=0`, `dout=0`, `out_valid=0`.
  - Any in-flight result is discarded and no `out_valid` is issued.

## Timing
- **Reset values:** `add=0`, `dout=0`, `out_valid=0`, `in_ready=1` (IDLE) from the first cycle after `clr` deasserts.
- **Cycle schedule:** sample accepted at the end of cycle 0 (IDLE, `in_valid=1`), then:
  - cycles 1..8: RUN with `add`=0..7 (`N_TAPS`=16)
  - cycles 2..9: `q`=h0..h7, accumulated
  - cycle 9: DRAIN
  - cycle 10: `out_valid=1`, `dout` valid, `in_ready=1`
- **Latency:** 10 cycles accept-to-`out_valid`; in general `N_TAPS/2 + 2`.
- **Throughput:** one sample per `N_TAPS/2 + 2` cycles.
- **`in_ready`:** equals state==IDLE, decoded from registered state.

## Test plan
ROM for all scenarios: h0..h7 = 1,2,3,4,5,6,7,8, 1-cycle read latency.
- **Impulse:** after `clr`, feed `din`=1 then 16 zeros, back-to-back.
  - Required `dout` sequence: 1,2,3,4,5,6,7,8,8,7,6,5,4,3,2,1, then 0.
  - One `out_valid` per sample, each exactly 10 cycles after accept.
- **DC:** feed 32 samples of `din`=1.
  - Output ramps up, reaching 72 from the 16th output on.
  - Every later output is 72; with `WIDTH_MAC_OUT`=8 that value saturates to 72 (no clamp).
- **Saturation:** constant `din`=127 gives steady output clamped to 127. Constant `din`=-128 gives steady output clamped to -128.
  - Repeat with `SHIFT`=7 and `WIDTH_MAC_OUT`=16: steady values 71 and -72.
- **Handshake:** hold `in_valid`=1 continuously.
  - `in_ready` is high exactly 1 cycle in every 10.
  - The delay line shifts only on those cycles.
  - Samples are never dropped or duplicated (check against a golden model).
  - `add` never exceeds 7.
- **Reset mid-operation:** assert `clr` in RUN cycle 4 (`add`=3).
  - Next cycle: `add=0`, `out_valid=0`, `dout=0`, `in_ready=1`.
  - No pulse from the aborted sample.
  - A following impulse reproduces the impulse response exactly (delay line cleared).
- **Idle gaps:** random 0–20-cycle gaps between samples give outputs identical to the back-to-back run of the same data.

Source files
------------

// File: rtl/fir_sym_mac.sv
// fir_sym_mac: symmetric FIR sequencer, pre-adder and multiply-accumulate with saturated output
module fir_sym_mac #(
   parameter int WIDTH_DATA    = 8,
   parameter int WIDTH_COEF0   = 8,
   parameter int N_TAPS        = 16,
   parameter int WIDTH_MAC_OUT = 8,
   parameter int SHIFT         = 0
) (
   input  logic                               clk,
   input  logic                               clr,
   input  logic signed [WIDTH_DATA-1:0]       din,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic [$clog2(N_TAPS/2)-1:0]        add,
   input  logic signed [WIDTH_COEF0-1:0]      q,
   output logic signed [WIDTH_MAC_OUT-1:0]    dout,
   output logic                               out_valid
);
   localparam int HALF = N_TAPS / 2;
   localparam int AAW  = $clog2(HALF);
   localparam int PW   = WIDTH_DATA + 1;
   localparam int MW   = PW + WIDTH_COEF0;
   localparam int ACCW = MW + AAW;
   localparam int EW   = (ACCW > WIDTH_MAC_OUT ? ACCW : WIDTH_MAC_OUT) + 1;
   localparam logic [AAW-1:0] LAST = AAW'(HALF - 1);
   localparam logic signed [EW-1:0] ONE  = EW'(1);
   localparam logic signed [EW-1:0] MAXV = (ONE <<< (WIDTH_MAC_OUT - 1)) - ONE;
   localparam logic signed [EW-1:0] MINV = -(ONE <<< (WIDTH_MAC_OUT - 1));

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                        state;
   logic signed [WIDTH_DATA-1:0]  x [N_TAPS];
   logic signed [PW-1:0]          p_reg;
   logic signed [PW-1:0]          p_k;
   logic signed [MW-1:0]          prod;
   logic signed [ACCW-1:0]        acc;
   logic signed [ACCW-1:0]        sum;
   logic signed [ACCW-1:0]        sh;
   logic signed [EW-1:0]          ext;
   logic signed [WIDTH_MAC_OUT-1:0] sat;

   assign in_ready = state == IDLE;

   // pre-add the mirrored pair at the current address; the mirror of k is N-1-k = {1, ~k}
   always_comb begin
      p_k  = PW'(x[add]) + PW'(x[{1'b1, ~add}]);
      prod = p_reg * q;
      sum  = acc + ACCW'(prod);
      sh   = sum >>> SHIFT;
      ext  = EW'(sh);
      sat  = ext > MAXV ? WIDTH_MAC_OUT'(MAXV) : ext < MINV ? WIDTH_MAC_OUT'(MINV) : ext[WIDTH_MAC_OUT-1:0];
   end

   // sequencer: accept in IDLE, walk the ROM in RUN (product lags the address by one), finish in DRAIN
   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         for (int i = 0; i < N_TAPS; i++) x[i] <= '0;
         acc       <= '0;
         p_reg     <= '0;
         add       <= '0;
         dout      <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: if (in_valid) begin
               x[0] <= din;
               for (int i = 1; i < N_TAPS; i++) x[i] <= x[i-1];
               acc   <= '0;
               add   <= '0;
               state <= RUN;
            end
            RUN: begin
               p_reg <= p_k;
               if (add != '0) acc <= sum;
               if (add == LAST) state <= DRAIN;
               else add <= add + 1'b1;
            end
            DRAIN: begin
               dout      <= sat;
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_sym_mac.sv
// tb_fir_sym_mac: scoreboard bench for fir_sym_mac in default and shifted/wide-output configurations
module tb_fir_sym_mac;
   logic clk = 1'b0;
   logic clr;
   logic signed [7:0] din;
   logic in_valid;
   logic in_ready1, in_ready2, ov1, ov2;
   logic [2:0] add1, add2;
   logic signed [7:0] q1, q2;
   logic signed [7:0] dout1;
   logic signed [15:0] dout2;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int max_add = 0;
   logic signed [7:0] mx [16];
   logic signed [7:0] dat [24];

   typedef struct {int c; longint e1; longint e2;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fir_sym_mac dut1 (.clk(clk), .clr(clr), .din(din), .in_valid(in_valid), .in_ready(in_ready1),
                     .add(add1), .q(q1), .dout(dout1), .out_valid(ov1));
   fir_sym_mac #(.WIDTH_MAC_OUT(16), .SHIFT(7)) dut2 (.clk(clk), .clr(clr), .din(din), .in_valid(in_valid),
                     .in_ready(in_ready2), .add(add2), .q(q2), .dout(dout2), .out_valid(ov2));

   // coefficient ROM h[k] = k+1 with one-cycle read latency
   always @(posedge clk) begin
      q1 <= 8'(add1) + 8'sd1;
      q2 <= 8'(add2) + 8'sd1;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint fir();
      longint s = 0;
      for (int i = 0; i < 16; i++) s += longint'(i < 8 ? i + 1 : 16 - i) * longint'(mx[i]);
      return s;
   endfunction

   function automatic longint clamp(input longint v, input int w);
      longint hi = (longint'(1) <<< (w - 1)) - 1;
      return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
   endfunction

   // golden direct-form model fed on every accept; outputs popped and compared on out_valid
   always @(negedge clk) begin
      exp_t e;
      if (clr) begin
         for (int i = 0; i < 16; i++) mx[i] = '0;
         sb.delete();
      end else begin
         if (in_valid && in_ready1) begin
            for (int i = 15; i > 0; i--) mx[i] = mx[i-1];
            mx[0] = din;
            sb.push_back('{cyc, clamp(fir(), 8), clamp(fir() >>> 7, 16)});
         end
         if (ov1) begin
            if (sb.size() == 0) check("spurious_out", ov1, 0);
            else begin
               e = sb.pop_front();
               check("dout", dout1, e.e1);
               check("dout_shift7", dout2, e.e2);
               check("latency", cyc - e.c, 10);
               check("ov_pair", ov2, 1);
            end
         end
      end
      if (int'(add1) > max_add) max_add = int'(add1);
   end

   task automatic send(input logic signed [7:0] v, output int w);
      bit ok = 0;
      w = 0;
      din = v;
      in_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         w++;
         ok = in_ready1;
      end
      if (!ok) check("send_timeout", ok, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic burst(input int n, input logic signed [7:0] v);
      int w;
      for (int i = 0; i < n; i++) begin
         send(v, w);
         if (i > 0) check("b2b_gap", w, 10);
      end
   endtask

   task automatic run_arr(input bit gaps);
      int w;
      for (int i = 0; i < 24; i++) begin
         send(dat[i], w);
         if (!gaps && i > 0) check("b2b_gap", w, 10);
         if (gaps) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1 check("drain_empty", sb.size(), 0);
   endtask

   task automatic impulse();
      burst(1, 8'sd1);
      burst(16, 8'sd0);
      drain();
      check("impulse_tail", dout1, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      int w;
      clr = 1'b1;
      in_valid = 1'b0;
      din = '0;
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      @(posedge clk);
      #1;
      check("rst_add", add1, 0);
      check("rst_dout", dout1, 0);
      check("rst_ov", ov1, 0);
      check("rst_ready", in_ready1, 1);
      check("rst_dout2", dout2, 0);

      impulse();

      burst(32, 8'sd1);
      drain();
      check("dc_steady", dout1, 72);

      burst(20, 8'sd127);
      drain();
      check("sat_pos", dout1, 127);
      check("shift_pos", dout2, 71);
      burst(20, -8'sd128);
      drain();
      check("sat_neg", dout1, -128);
      check("shift_neg", dout2, -72);

      send(8'sd5, w);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = add1 == 3'd3 && !in_ready1;
      end
      check("wait_add3", ok, 1);
      #1 clr = 1'b1;
      @(posedge clk);
      #1;
      check("clr_add", add1, 0);
      check("clr_ov", ov1, 0);
      check("clr_dout", dout1, 0);
      check("clr_ready", in_ready1, 1);
      @(negedge clk);
      #1 clr = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      impulse();

      for (int i = 0; i < 24; i++) dat[i] = 8'($urandom_range(0, 255));
      run_arr(1'b0);
      drain();
      run_arr(1'b1);
      drain();

      check("add_max", max_add, 7);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
